// File: rtl/lever_accel_frontend.sv
// Lever acceleration front end for the pendulum simulator.
// On each sim tick it snapshots the lever ADC words, the enable mask and the
// pendulum position. It then fetches gravity for the wrapped position and adds
// every enabled lever, scaled to PF 16.16 step/clock. The saturated total is
// presented with a one-cycle valid strobe.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for sim tick; results held
// ADDR   | register wrapped gravity ROM address from latched position
// GRAV   | load accumulator with sign-extended gravity word
// MAC    | one lever channel per cycle through the shared multiplier
// DONE   | clamp accumulator to 32 bits, present result with valid
module lever_accel_frontend #(
  parameter int          N_LEVERS      = 2,
  parameter int          ADC_BITS      = 16,
  parameter logic [23:0] SCALE_K       = 24'h801A36,
  parameter int          SCALE_SHIFT   = 10,
  parameter int          STEPS_PER_REV = 3200,
  parameter int          ROM_ADDR_BITS = 12
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_sim_tick,
  input  logic [N_LEVERS*ADC_BITS-1:0] i_lever_bits,
  input  logic [N_LEVERS-1:0]          i_lever_enable,
  input  logic [15:0]                  i_current_pos,
  output logic [ROM_ADDR_BITS-1:0]     o_gravity_rom_addr,
  input  logic [31:0]                  i_gravity_data,
  output logic [31:0]                  o_accel_out,
  output logic                         o_accel_valid,
  output logic                         o_busy,
  output logic                         o_sat_flag,
  output logic                         o_overrun
);

  localparam int ACC_W  = 48;
  localparam int PROD_W = ADC_BITS + 25;
  localparam int CHAN_W = (N_LEVERS > 1) ? $clog2(N_LEVERS) : 1;

  localparam logic [CHAN_W-1:0]       LAST_CHAN = CHAN_W'(N_LEVERS - 1);
  localparam logic signed [16:0]      STEPS_S   = 17'(STEPS_PER_REV);
  // Scale factor is unsigned; a zero sign bit keeps the multiply signed.
  localparam logic signed [24:0]      K_S       = {1'b0, SCALE_K};
  localparam logic signed [ACC_W-1:0] ACC_MAX   = 48'sh0000_7FFF_FFFF;
  localparam logic signed [ACC_W-1:0] ACC_MIN   = 48'shFFFF_8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GRAV,
    S_MAC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [N_LEVERS*ADC_BITS-1:0] r_lever_bits;
  logic [N_LEVERS-1:0]          r_lever_en;
  logic signed [15:0]           r_pos;
  logic [CHAN_W-1:0]            r_chan;
  logic signed [ACC_W-1:0]      r_acc;
  logic [ROM_ADDR_BITS-1:0]     r_rom_addr;
  logic [31:0]                  r_accel_out;
  logic                         r_sat;
  logic                         r_overrun;

  logic signed [16:0]           w_pos_ext;
  logic [ROM_ADDR_BITS-1:0]     w_addr_wrapped;
  logic signed [ADC_BITS-1:0]   w_lever;
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [PROD_W-1:0]     w_scaled;
  logic signed [ACC_W-1:0]      w_mac_term;
  logic signed [ACC_W-1:0]      w_grav_ext;
  logic [31:0]                  w_clamp;
  logic                         w_sat;
  logic                         w_last_chan;

  assign w_pos_ext   = 17'(r_pos);
  assign w_lever     = r_lever_bits[r_chan*ADC_BITS +: ADC_BITS];
  assign w_prod      = PROD_W'(w_lever) * PROD_W'(K_S);
  // Arithmetic shift floors toward -inf, matching the simulator's fixed-point model.
  assign w_scaled    = w_prod >>> SCALE_SHIFT;
  assign w_mac_term  = ACC_W'(w_scaled);
  assign w_grav_ext  = ACC_W'($signed(i_gravity_data));
  assign w_last_chan = (r_chan == LAST_CHAN);

  // Single-correction wrap of the latched position into one revolution.
  always_comb begin
    w_addr_wrapped = ROM_ADDR_BITS'(w_pos_ext);
    if (w_pos_ext < 17'sd0) begin
      w_addr_wrapped = ROM_ADDR_BITS'(w_pos_ext + STEPS_S);
    end else if (w_pos_ext >= STEPS_S) begin
      w_addr_wrapped = ROM_ADDR_BITS'(w_pos_ext - STEPS_S);
    end
  end

  // Saturate the 48-bit accumulator to a signed 32-bit result.
  always_comb begin
    w_clamp = r_acc[31:0];
    w_sat   = 1'b0;
    if (r_acc > ACC_MAX) begin
      w_clamp = 32'h7FFF_FFFF;
      w_sat   = 1'b1;
    end else if (r_acc < ACC_MIN) begin
      w_clamp = 32'h8000_0000;
      w_sat   = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode; DONE forwards the clamped value so data and valid coincide.
  always_comb begin
    w_next_state  = r_state;
    o_busy        = (r_state != S_IDLE);
    o_accel_valid = 1'b0;
    o_accel_out   = r_accel_out;
    o_sat_flag    = r_sat;
    case (r_state)
      S_IDLE: begin
        if (i_sim_tick) begin
          w_next_state = S_ADDR;
        end
      end
      S_ADDR: begin
        w_next_state = S_GRAV;
      end
      S_GRAV: begin
        w_next_state = S_MAC;
      end
      S_MAC: begin
        if (w_last_chan) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state  = S_IDLE;
        o_accel_valid = 1'b1;
        o_accel_out   = w_clamp;
        o_sat_flag    = w_sat;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Input snapshot, address, accumulator and held result registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_lever_bits <= '0;
      r_lever_en   <= '0;
      r_pos        <= '0;
      r_chan       <= '0;
      r_acc        <= '0;
      r_rom_addr   <= '0;
      r_accel_out  <= '0;
      r_sat        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_sim_tick) begin
            r_lever_bits <= i_lever_bits;
            r_lever_en   <= i_lever_enable;
            r_pos        <= $signed(i_current_pos);
            r_chan       <= '0;
          end
        end
        S_ADDR: begin
          r_rom_addr <= w_addr_wrapped;
        end
        S_GRAV: begin
          r_acc <= w_grav_ext;
        end
        S_MAC: begin
          if (r_lever_en[r_chan]) begin
            r_acc <= r_acc + w_mac_term;
          end
          if (!w_last_chan) begin
            r_chan <= r_chan + CHAN_W'(1);
          end
        end
        S_DONE: begin
          r_accel_out <= w_clamp;
          r_sat       <= w_sat;
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky flag for a tick that arrives while a computation is in flight.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_overrun <= 1'b0;
    end else if (i_sim_tick && (r_state != S_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_gravity_rom_addr = r_rom_addr;
  assign o_overrun          = r_overrun;

endmodule

// File: tb/tb_lever_accel_frontend.sv
// Directed bench for lever_accel_frontend with N_LEVERS=2.
module tb_lever_accel_frontend;

  logic        i_clock;
  logic        i_reset;
  logic        i_sim_tick;
  logic [31:0] i_lever_bits;
  logic [1:0]  i_lever_enable;
  logic [15:0] i_current_pos;
  logic [11:0] o_gravity_rom_addr;
  logic [31:0] i_gravity_data;
  logic [31:0] o_accel_out;
  logic        o_accel_valid;
  logic        o_busy;
  logic        o_sat_flag;
  logic        o_overrun;

  int n_pass  = 0;
  int n_total = 0;

  lever_accel_frontend dut (
    .i_clock            (i_clock),
    .i_reset            (i_reset),
    .i_sim_tick         (i_sim_tick),
    .i_lever_bits       (i_lever_bits),
    .i_lever_enable     (i_lever_enable),
    .i_current_pos      (i_current_pos),
    .o_gravity_rom_addr (o_gravity_rom_addr),
    .i_gravity_data     (i_gravity_data),
    .o_accel_out        (o_accel_out),
    .o_accel_valid      (o_accel_valid),
    .o_busy             (o_busy),
    .o_sat_flag         (o_sat_flag),
    .o_overrun          (o_overrun)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [31:0] lever;
    logic [1:0]  en;
    logic [15:0] pos;
    logic [31:0] grav;
    logic [11:0] exp_addr;
    logic [31:0] exp_acc;
    logic        exp_sat;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One tick with vector v; inputs are scrambled after the tick. second_at>0
  // injects a second tick that many cycles after the first.
  task automatic run_vec(input vec_t v, input string tag, input int second_at);
    int          lat;
    int          nval;
    logic [31:0] acc;
    logic        sat;
    lat = 0; nval = 0; acc = '0; sat = 1'b0;
    @(negedge i_clock);
    i_lever_bits   = v.lever;
    i_lever_enable = v.en;
    i_current_pos  = v.pos;
    i_gravity_data = v.grav;
    i_sim_tick     = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge i_clock);
      if (o_accel_valid) begin
        nval++;
        if (lat == 0) begin
          lat = k;
          acc = o_accel_out;
          sat = o_sat_flag;
        end
      end
      if (k == 3) chk({tag, "_busy_mid"}, 32'(o_busy), 32'd1);
      i_sim_tick     = (k == second_at);
      i_lever_bits   = ~v.lever;
      i_lever_enable = ~v.en;
      i_current_pos  = v.pos + 16'd7;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd5);
    chk({tag, "_nvalid"}, 32'(nval), 32'd1);
    chk({tag, "_accel"}, acc, v.exp_acc);
    chk({tag, "_sat"}, 32'(sat), 32'(v.exp_sat));
    chk({tag, "_addr"}, 32'(o_gravity_rom_addr), 32'(v.exp_addr));
    chk({tag, "_hold"}, o_accel_out, v.exp_acc);
    chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int nval;
    vecs[0]  = '{32'h0000_0004, 2'b01, 16'h0000, 32'h0000_0000, 12'd0,    32'h0000_801A, 1'b0};
    vecs[1]  = '{32'h0000_FFFC, 2'b01, 16'h0000, 32'h0000_0000, 12'd0,    32'hFFFF_7FE5, 1'b0};
    vecs[2]  = '{32'h5555_AAAA, 2'b00, 16'hFFFF, 32'h0001_2345, 12'd3199, 32'h0001_2345, 1'b0};
    vecs[3]  = '{32'h0004_1234, 2'b10, 16'h0C80, 32'h0000_0000, 12'd0,    32'h0000_801A, 1'b0};
    vecs[4]  = '{32'h0004_0004, 2'b11, 16'h0C7F, 32'h0001_0000, 12'd3199, 32'h0002_0034, 1'b0};
    vecs[5]  = '{32'h0000_FFFC, 2'b01, 16'h18FF, 32'h0001_0000, 12'd3199, 32'h0000_7FE5, 1'b0};
    vecs[6]  = '{32'h7FFF_7FFF, 2'b11, 16'h0005, 32'h7FFF_0000, 12'd5,    32'h7FFF_FFFF, 1'b1};
    vecs[7]  = '{32'h8000_8000, 2'b11, 16'hF380, 32'h8001_0000, 12'd0,    32'h8000_0000, 1'b1};
    vecs[8]  = '{32'h1234_5678, 2'b00, 16'h0640, 32'h8000_0000, 12'd1600, 32'h8000_0000, 1'b0};
    vecs[9]  = '{32'h0000_7FFF, 2'b01, 16'h0001, 32'h5FFF_0000, 12'd1,    32'h7002_26B9, 1'b0};
    vecs[10] = '{32'h7FFF_7FFF, 2'b11, 16'h0002, 32'h5FF9_B28D, 12'd2,    32'h7FFF_FFFF, 1'b0};
    vecs[11] = '{32'h7FFF_7FFF, 2'b11, 16'h0003, 32'h5FF9_B28E, 12'd3,    32'h7FFF_FFFF, 1'b1};

    i_reset = 1'b1; i_sim_tick = 1'b0; i_lever_bits = '0; i_lever_enable = '0;
    i_current_pos = '0; i_gravity_data = '0;
    repeat (3) @(negedge i_clock);
    chk("rst_accel", o_accel_out, 32'h0);
    chk("rst_addr", 32'(o_gravity_rom_addr), 32'h0);
    chk("rst_flags", {28'h0, o_accel_valid, o_busy, o_sat_flag, o_overrun}, 32'h0);
    i_reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i), 0);
    chk("overrun_clear", 32'(o_overrun), 32'd0);

    // Second tick two cycles into a computation: ignored, flagged as overrun.
    run_vec(vecs[0], "ovr", 2);
    chk("overrun_set", 32'(o_overrun), 32'd1);
    repeat (5) @(negedge i_clock);
    chk("overrun_sticky", 32'(o_overrun), 32'd1);

    // Reset during the first MAC cycle aborts the computation.
    nval = 0;
    @(negedge i_clock);
    i_lever_bits = 32'h0000_0004; i_lever_enable = 2'b01; i_current_pos = 16'd100;
    i_gravity_data = 32'h0001_0000; i_sim_tick = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge i_clock);
      if (o_accel_valid) nval++;
      i_sim_tick = 1'b0;
      if (k == 3) i_reset = 1'b1;
      if (k == 4) begin
        chk("abort_accel", o_accel_out, 32'h0);
        chk("abort_addr", 32'(o_gravity_rom_addr), 32'h0);
        chk("abort_flags", {28'h0, o_accel_valid, o_busy, o_sat_flag, o_overrun}, 32'h0);
        i_reset = 1'b0;
      end
    end
    chk("abort_nvalid", 32'(nval), 32'd0);
    run_vec(vecs[4], "after_abort", 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
